// File: rtl/acc_wrapp.sv
// rtl/acc_wrapp.sv - packet accumulator closing the dot product after the multiplier
package acc_wrapp_pkg;

  localparam int PIPE_WORD_WDT = 16;
  localparam int PIPE_TYPE_WDT = 4;

  typedef enum logic [1:0] {
    FIXED_POINT_GENERIC = 2'd0,
    FIXED_POINT_INTEGER = 2'd1
  } arith_type_e;

  typedef struct packed {
    int int_wdt;
    int frac_wdt;
  } fxp_cfg_t;

  typedef struct packed {
    int          word_wdt;
    fxp_cfg_t    fxp_cfg;
    arith_type_e arith_type;
    logic        arith_satur;
  } arith_cfg_t;

  typedef struct packed {
    logic [PIPE_WORD_WDT-1:0] data_word;
    logic                     data_val;
    logic                     data_last;
    logic [PIPE_TYPE_WDT-1:0] data_type;
  } pipe_data_t;

  localparam arith_cfg_t ACC_ARITH_CFG_DEF = '{
    word_wdt:    PIPE_WORD_WDT,
    fxp_cfg:     '{int_wdt: 8, frac_wdt: 8},
    arith_type:  FIXED_POINT_GENERIC,
    arith_satur: 1'b1
  };

endpackage

module acc_wrapp
  import acc_wrapp_pkg::*;
#(
  parameter arith_cfg_t ACC_ARITH_CFG = ACC_ARITH_CFG_DEF,
  parameter int         ACC_GUARD_WDT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  pipe_data_t acc_op,
  output pipe_data_t acc_res,
  output logic       acc_type_err
);

  localparam int  W     = ACC_ARITH_CFG.word_wdt;
  localparam int  G     = ACC_GUARD_WDT;
  localparam int  AW    = W + G;
  localparam bit  SATUR = ACC_ARITH_CFG.arith_satur;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [PIPE_TYPE_WDT-1:0] type_q, type_d;
  logic                     err_q, err_d;
  pipe_data_t               res_q, res_d;

  logic [AW-1:0]            beat_ext;
  logic [AW-1:0]            sum;

  // Add in AW+1 bits; on overflow either clamp to the AW-bit limits or keep the wrapped low bits.
  function automatic logic [AW-1:0] add_sat(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (SATUR && (s[AW] != s[AW-1])) begin
      add_sat = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      add_sat = s[AW-1:0];
    end
  endfunction

  // Narrow the guarded accumulator back to W bits; the guard bits must all match the sign to fit.
  function automatic logic [W-1:0] out_clamp(input logic [AW-1:0] a);
    if (SATUR && (a[AW-1:W-1] != {(G+1){a[AW-1]}})) begin
      out_clamp = a[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      out_clamp = a[W-1:0];
    end
  endfunction

  assign beat_ext = {{G{acc_op.data_word[W-1]}}, acc_op.data_word[W-1:0]};
  assign sum      = add_sat(acc_q, beat_ext);

  // Next-state: packet FSM, running sum, captured type, sticky error and the result beat.
  always_comb begin
    state_d           = state_q;
    acc_d             = acc_q;
    type_d            = type_q;
    err_d             = err_q;
    res_d             = res_q;
    res_d.data_val    = 1'b0;
    res_d.data_last   = 1'b0;
    if (acc_op.data_val) begin
      case (state_q)
        IDLE: begin
          if (acc_op.data_last) begin
            res_d.data_word = out_clamp(beat_ext);
            res_d.data_val  = 1'b1;
            res_d.data_last = 1'b1;
            res_d.data_type = acc_op.data_type;
          end else begin
            acc_d   = beat_ext;
            type_d  = acc_op.data_type;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (acc_op.data_type != type_q) begin
            err_d = 1'b1;
          end
          if (acc_op.data_last) begin
            res_d.data_word = out_clamp(sum);
            res_d.data_val  = 1'b1;
            res_d.data_last = 1'b1;
            res_d.data_type = type_q;
            acc_d           = '0;
            state_d         = IDLE;
          end else begin
            acc_d = sum;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; clk_en low freezes everything, including a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      type_q  <= type_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign acc_res      = res_q;
  assign acc_type_err = err_q;

endmodule

// File: tb/tb_acc_wrapp.sv
// tb/tb_acc_wrapp.sv - directed bench for the packet accumulator
module tb_acc_wrapp;
  import acc_wrapp_pkg::*;

  localparam arith_cfg_t CFG_WRAP = '{
    word_wdt:    16,
    fxp_cfg:     '{int_wdt: 8, frac_wdt: 8},
    arith_type:  FIXED_POINT_GENERIC,
    arith_satur: 1'b0
  };

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  pipe_data_t acc_op;
  pipe_data_t res_s, res_w;
  logic       err_s, err_w;

  int n_checks = 0;
  int n_fail   = 0;

  acc_wrapp #(.ACC_ARITH_CFG(ACC_ARITH_CFG_DEF), .ACC_GUARD_WDT(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .acc_op(acc_op),
    .acc_res(res_s), .acc_type_err(err_s)
  );

  acc_wrapp #(.ACC_ARITH_CFG(CFG_WRAP), .ACC_GUARD_WDT(8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .acc_op(acc_op),
    .acc_res(res_w), .acc_type_err(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one beat with clk_en=1, then sample 1 time unit after the edge.
  task automatic beat(input logic [15:0] w, input logic v, input logic l, input logic [3:0] t);
    clk_en           = 1'b1;
    acc_op.data_word = w;
    acc_op.data_val  = v;
    acc_op.data_last = l;
    acc_op.data_type = t;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    clk_en = 1'b1;
    acc_op = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (res_s !== '0) begin
      n_fail++; $display("FAIL reset_res: got %h expected %h", res_s, 16'h0);
    end
    n_checks++;
    if (err_s !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", err_s);
    end
    rst_n = 1'b1;
    beat(16'h0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_basic();
    beat(16'h0100, 1'b1, 1'b0, 4'd0);
    n_checks++;
    if (res_s.data_val !== 1'b0) begin
      n_fail++; $display("FAIL t1_val_b1: got %b expected 0", res_s.data_val);
    end
    beat(16'h0200, 1'b1, 1'b0, 4'd0);
    n_checks++;
    if (res_s.data_val !== 1'b0) begin
      n_fail++; $display("FAIL t1_val_b2: got %b expected 0", res_s.data_val);
    end
    beat(16'h0300, 1'b1, 1'b1, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val, res_s.data_last} !== {16'h0600, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL t1_result: got word=%h val=%b last=%b expected word=0600 val=1 last=1",
                         res_s.data_word, res_s.data_val, res_s.data_last);
    end
    beat(16'h0000, 1'b0, 1'b0, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val, res_s.data_last} !== {16'h0600, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL t1_after: got word=%h val=%b last=%b expected word=0600 val=0 last=0",
                         res_s.data_word, res_s.data_val, res_s.data_last);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) beat(16'h7000, 1'b1, (i == 3), 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val} !== {16'h7FFF, 1'b1}) begin
      n_fail++; $display("FAIL t2_pos_sat: got word=%h val=%b expected 7fff/1", res_s.data_word, res_s.data_val);
    end
    n_checks++;
    if ({res_w.data_word, res_w.data_val} !== {16'hC000, 1'b1}) begin
      n_fail++; $display("FAIL t2_pos_wrap: got word=%h val=%b expected c000/1", res_w.data_word, res_w.data_val);
    end
    for (int i = 0; i < 2; i++) beat(16'h8000, 1'b1, (i == 1), 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val} !== {16'h8000, 1'b1}) begin
      n_fail++; $display("FAIL t2_neg_sat: got word=%h val=%b expected 8000/1", res_s.data_word, res_s.data_val);
    end
    n_checks++;
    if ({res_w.data_word, res_w.data_val} !== {16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL t2_neg_wrap: got word=%h val=%b expected 0000/1", res_w.data_word, res_w.data_val);
    end
  endtask

  task automatic test_clk_en();
    beat(16'h0100, 1'b1, 1'b0, 4'd0);
    beat(16'h0200, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      clk_en           = 1'b0;
      acc_op.data_word = 16'h1234;
      acc_op.data_val  = 1'b1;
      acc_op.data_last = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({res_s.data_word, res_s.data_val} !== {16'h8000, 1'b0}) begin
        n_fail++; $display("FAIL t3_frozen%0d: got word=%h val=%b expected 8000/0", i, res_s.data_word, res_s.data_val);
      end
    end
    beat(16'h0300, 1'b1, 1'b1, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val, res_s.data_last} !== {16'h0600, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL t3_result: got word=%h val=%b last=%b expected 0600/1/1",
                         res_s.data_word, res_s.data_val, res_s.data_last);
    end
  endtask

  task automatic test_back_to_back();
    beat(16'hFF00, 1'b1, 1'b1, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val} !== {16'hFF00, 1'b1}) begin
      n_fail++; $display("FAIL t4_single: got word=%h val=%b expected ff00/1", res_s.data_word, res_s.data_val);
    end
    beat(16'h0080, 1'b1, 1'b0, 4'd0);
    n_checks++;
    if (res_s.data_val !== 1'b0) begin
      n_fail++; $display("FAIL t4_gap_val: got %b expected 0", res_s.data_val);
    end
    beat(16'h0080, 1'b1, 1'b1, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val} !== {16'h0100, 1'b1}) begin
      n_fail++; $display("FAIL t4_second: got word=%h val=%b expected 0100/1", res_s.data_word, res_s.data_val);
    end
  endtask

  task automatic test_type_err();
    beat(16'h0001, 1'b1, 1'b0, 4'd2);
    beat(16'h0001, 1'b1, 1'b0, 4'd2);
    n_checks++;
    if (err_s !== 1'b0) begin
      n_fail++; $display("FAIL t5_err_early: got %b expected 0", err_s);
    end
    beat(16'h0001, 1'b1, 1'b1, 4'd5);
    n_checks++;
    if ({res_s.data_word, res_s.data_val, res_s.data_type, err_s} !== {16'h0003, 1'b1, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL t5_result: got word=%h val=%b type=%0d err=%b expected 0003/1/2/1",
                         res_s.data_word, res_s.data_val, res_s.data_type, err_s);
    end
    beat(16'h0000, 1'b0, 1'b0, 4'd0);
    beat(16'h0000, 1'b0, 1'b0, 4'd0);
    n_checks++;
    if (err_s !== 1'b1) begin
      n_fail++; $display("FAIL t5_err_sticky: got %b expected 1", err_s);
    end
  endtask

  task automatic test_mid_reset();
    beat(16'h0100, 1'b1, 1'b0, 4'd0);
    beat(16'h0100, 1'b1, 1'b0, 4'd0);
    acc_op = '0;
    rst_n  = 1'b0;
    #1;
    n_checks++;
    if ({res_s, err_s} !== '0) begin
      n_fail++; $display("FAIL t6_in_reset: got res=%h err=%b expected all 0", res_s, err_s);
    end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(16'h0100, 1'b1, 1'b1, 4'd0);
    n_checks++;
    if ({res_s.data_word, res_s.data_val, res_s.data_last} !== {16'h0100, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL t6_result: got word=%h val=%b last=%b expected 0100/1/1",
                         res_s.data_word, res_s.data_val, res_s.data_last);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_clk_en();
    test_back_to_back();
    test_type_err();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
